// File: rtl/pll_ctrl_pkg.sv
// Shared types for the PLL reset sequencer: FSM state encoding, output bundle,
// and the constant helpers used to size its counters.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_t;

    localparam int LOST_CNT_W = 8;

    // Registered control outputs, kept together so one assignment sets them all
    typedef struct packed {
        logic pll_resetb;
        logic rstn;
        logic locked;
        logic fail;
    } ctrl_out_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Output values that belong to a given state
    function automatic ctrl_out_t state_outs(input pll_state_t s);
        ctrl_out_t o;
        o.pll_resetb = (s == ST_WAIT_LOCK) || (s == ST_STABLE) || (s == ST_RUN);
        o.rstn       = (s == ST_RUN);
        o.locked     = (s == ST_RUN);
        o.fail       = (s == ST_FAIL);
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    // Shift the async input through two flops before anyone looks at it
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            meta <= 1'b0;
            q_o  <= 1'b0;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_ctrl.sv
// SB_PLL40_CORE sequencer: pulses RESETB, waits for a qualified LOCK, then
// releases the system reset; re-sequences on lock loss, gives up after
// MAX_RETRIES timeouts (0 = never give up).
module pll_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  pll_lock_i,
    input  logic                  restart_i,
    output logic                  pll_resetb_o,
    output logic                  rstn_o,
    output logic                  locked_o,
    output logic                  fail_o,
    output logic [LOST_CNT_W-1:0] lost_count_o
);

    localparam int CNT_W  = $clog2(max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
    localparam int RTY_RW = $clog2(MAX_RETRIES + 1);
    localparam int RTY_W  = (RTY_RW < 1) ? 1 : RTY_RW;

    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    // Retry count that, once incremented, reaches MAX_RETRIES
    localparam logic [RTY_W-1:0] RTY_LAST     = (MAX_RETRIES > 0) ? RTY_W'(MAX_RETRIES - 1) : '0;

    pll_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic [RTY_W-1:0]      retries;
    logic [LOST_CNT_W-1:0] lost;
    ctrl_out_t             outs;
    logic                  lock_s;

    sync_2ff u_lock_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (pll_lock_i),
        .q_o    (lock_s)
    );

    // Sequencer FSM; outputs are registered alongside the state they belong to,
    // so rstn_o falls on the same edge the state leaves RUN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= ST_RESET;
            cnt     <= '0;
            retries <= '0;
            lost    <= '0;
            outs    <= '0;
        end else if (restart_i) begin
            state   <= ST_RESET;
            cnt     <= '0;
            retries <= '0;
            outs    <= state_outs(ST_RESET);
        end else begin
            cnt <= cnt + 1'b1;
            unique case (state)
                ST_RESET: begin
                    if (cnt == RESET_LAST) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                        outs  <= state_outs(ST_WAIT_LOCK);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                        outs  <= state_outs(ST_STABLE);
                    end else if (cnt == TIMEOUT_LAST) begin
                        retries <= retries + 1'b1;
                        cnt     <= '0;
                        if (MAX_RETRIES != 0 && retries == RTY_LAST) begin
                            state <= ST_FAIL;
                            outs  <= state_outs(ST_FAIL);
                        end else begin
                            state <= ST_RESET;
                            outs  <= state_outs(ST_RESET);
                        end
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        // Lock bounced before qualifying: fresh timeout, no retry charged
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                        outs  <= state_outs(ST_WAIT_LOCK);
                    end else if (cnt == STABLE_LAST) begin
                        state   <= ST_RUN;
                        cnt     <= '0;
                        retries <= '0;
                        outs    <= state_outs(ST_RUN);
                    end
                end
                ST_RUN: begin
                    cnt <= cnt;
                    if (!lock_s) begin
                        state <= ST_RESET;
                        cnt   <= '0;
                        outs  <= state_outs(ST_RESET);
                        if (lost != {LOST_CNT_W{1'b1}})
                            lost <= lost + 1'b1;
                    end
                end
                ST_FAIL: begin
                    cnt <= cnt;
                end
                default: begin
                    state <= ST_RESET;
                    cnt   <= '0;
                    outs  <= state_outs(ST_RESET);
                end
            endcase
        end
    end

    assign pll_resetb_o = outs.pll_resetb;
    assign rstn_o       = outs.rstn;
    assign locked_o     = outs.locked;
    assign fail_o       = outs.fail;
    assign lost_count_o = lost;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: randomized lock/restart/reset stimulus, an
// event-timestamp reference model, and a monitor that checks every change of
// the DUT outputs against the queued expectations.
module tb_pll_reset_ctrl;

    localparam int R    = 4;
    localparam int T    = 32;
    localparam int S    = 8;
    localparam int MAXR = 2;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STB  = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    logic       clk = 1'b0;
    logic       rstn_i = 1'b1;
    logic       pll_lock_i = 1'b0;
    logic       restart_i = 1'b0;
    logic       pll_resetb_o, rstn_o, locked_o, fail_o;
    logic [7:0] lost_count_o;

    pll_reset_ctrl #(
        .RESET_CYCLES (R),
        .LOCK_TIMEOUT (T),
        .STABLE_CYCLES(S),
        .MAX_RETRIES  (MAXR)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn_i),
        .pll_lock_i   (pll_lock_i),
        .restart_i    (restart_i),
        .pll_resetb_o (pll_resetb_o),
        .rstn_o       (rstn_o),
        .locked_o     (locked_o),
        .fail_o       (fail_o),
        .lost_count_o (lost_count_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] v;
        int          cyc;
    } ev_t;
    ev_t q[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model: phase plus the edge at which it was entered; the edge
    // count since entry replaces any explicit counter.
    int          m_phase = P_RST;
    int          m_entry = 0;
    int          m_tries = 0;
    int          m_lost  = 0;
    int          m_last_k = 0;
    bit          h1 = 1'b0, h2 = 1'b0;
    logic [11:0] m_prev = '0;

    function automatic logic [11:0] exp_vec();
        logic rb;
        rb = (m_phase == P_WAIT) || (m_phase == P_STB) || (m_phase == P_RUN);
        return {rb, m_phase == P_RUN, m_phase == P_RUN, m_phase == P_FAIL, 8'(m_lost)};
    endfunction

    task automatic push_if_changed(input int k);
        logic [11:0] v;
        ev_t e;
        v = exp_vec();
        if (v !== m_prev) begin
            e.v = v;
            e.cyc = k;
            q.push_back(e);
        end
        m_prev = v;
    endtask

    task automatic go(input int p, input int k);
        m_phase = p;
        m_entry = k;
    endtask

    // One active clock edge with the given inputs
    task automatic model_edge(input bit lk, input bit rs);
        int  k;
        int  age;
        bit  ls;
        k   = cyc + 1;
        ls  = h2;           // lock seen by the controller lags the pin by two edges
        h2  = h1;
        h1  = lk;
        age = k - m_entry - 1;
        m_last_k = k;
        if (rs) begin
            go(P_RST, k);
            m_tries = 0;
        end else begin
            case (m_phase)
                P_RST:  if (age == R - 1) go(P_WAIT, k);
                P_WAIT: begin
                    if (ls) go(P_STB, k);
                    else if (age == T - 1) begin
                        m_tries++;
                        if (MAXR != 0 && m_tries == MAXR) go(P_FAIL, k);
                        else go(P_RST, k);
                    end
                end
                P_STB: begin
                    if (!ls) go(P_WAIT, k);
                    else if (age == S - 1) begin
                        go(P_RUN, k);
                        m_tries = 0;
                    end
                end
                P_RUN: begin
                    if (!ls) begin
                        go(P_RST, k);
                        if (m_lost < 255) m_lost++;
                    end
                end
                default: ;
            endcase
        end
        push_if_changed(k);
    endtask

    function automatic int next_age();
        return m_last_k - m_entry;
    endfunction

    task automatic tick(input bit lk, input bit rs);
        @(negedge clk);
        pll_lock_i = lk;
        restart_i  = rs;
        model_edge(lk, rs);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rstn_i = 1'b1;
        m_entry = cyc;
        model_edge(pll_lock_i, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn_i    = 1'b0;
        restart_i = 1'b0;
        m_phase = P_RST;
        m_tries = 0;
        m_lost  = 0;
        h1 = 1'b0;
        h2 = 1'b0;
        push_if_changed(cyc + 1);
        repeat (2) @(negedge clk);
        release_reset();
    endtask

    task automatic run_until(input bit lk, input int phase, input int budget, input string name);
        int n;
        n = 0;
        while (m_phase != phase && n < budget) begin
            tick(lk, 1'b0);
            n++;
        end
        if (m_phase != phase) begin
            errors++;
            $display("FAIL bound %s: phase %0d after %0d cycles, required %0d", name, m_phase, n, phase);
        end
    endtask

    // Monitor: every change of the output vector must match the next expected event
    initial begin
        logic [11:0] prev, cur;
        ev_t e;
        prev = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                cur = {pll_resetb_o, rstn_o, locked_o, fail_o, lost_count_o};
                if (cur !== prev) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change: cycle %0d got %h, required no change from %h", cyc, cur, prev);
                    end else begin
                        e = q.pop_front();
                        if (cur !== e.v || e.cyc != cyc) begin
                            errors++;
                            $display("FAIL out_event: got %h at cycle %0d, required %h at cycle %0d", cur, cyc, e.v, e.cyc);
                        end
                    end
                    prev = cur;
                end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                    checks++;
                    errors++;
                    e = q.pop_front();
                    $display("FAIL missing_event: output stayed %h at cycle %0d, required %h at cycle %0d", cur, cyc, e.v, e.cyc);
                end
            end
        end
    end

    initial begin
        bit lk;
        #2 rstn_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 5;
        if (pll_resetb_o !== 1'b0) begin errors++; $display("FAIL rst_pll_resetb: got %b, required 0", pll_resetb_o); end
        if (rstn_o !== 1'b0)       begin errors++; $display("FAIL rst_rstn: got %b, required 0", rstn_o); end
        if (locked_o !== 1'b0)     begin errors++; $display("FAIL rst_locked: got %b, required 0", locked_o); end
        if (fail_o !== 1'b0)       begin errors++; $display("FAIL rst_fail: got %b, required 0", fail_o); end
        if (lost_count_o !== 8'd0) begin errors++; $display("FAIL rst_lost: got %0d, required 0", lost_count_o); end
        mon_en = 1'b1;
        release_reset();

        // No lock at all: two timeouts, then FAIL; restart from FAIL
        run_until(1'b0, P_FAIL, 200, "to_fail");
        repeat (10) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);

        // Lock appears 10 cycles after RESETB rises
        run_until(1'b0, P_WAIT, 20, "to_wait");
        repeat (10) tick(1'b0, 1'b0);
        run_until(1'b1, P_RUN, 60, "first_lock");
        repeat (20) tick(1'b1, 1'b0);

        // One-cycle lock drop in RUN, then relock
        tick(1'b0, 1'b0);
        run_until(1'b1, P_RUN, 100, "relock");
        repeat (5) tick(1'b1, 1'b0);

        // Glitch that reaches the controller at stable count 5
        tick(1'b0, 1'b0);
        run_until(1'b1, P_STB, 100, "to_stable");
        while (m_phase == P_STB && next_age() < 3) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        run_until(1'b1, P_RUN, 100, "after_glitch");
        repeat (5) tick(1'b1, 1'b0);

        // Restart on the very edge of the second timeout: no FAIL
        begin
            int n;
            n = 0;
            while (!(m_phase == P_WAIT && m_tries == 1 && next_age() == T - 1) && n < 300) begin
                tick(1'b0, 1'b0);
                n++;
            end
            if (n >= 300) begin
                errors++;
                $display("FAIL bound timeout_restart: not reached after %0d cycles, required < 300", n);
            end
        end
        tick(1'b0, 1'b1);
        repeat (50) tick(1'b0, 1'b0);
        run_until(1'b1, P_RUN, 100, "after_restart");

        // Randomized lock wander with occasional restart and reset
        lk = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) lk = ~lk;
            if ($urandom_range(0, 699) == 0) do_reset();
            else tick(lk, $urandom_range(0, 149) == 0);
        end

        // Lock-loss counter saturation
        for (int i = 0; i < 260; i++) begin
            run_until(1'b1, P_RUN, 120, "sat_relock");
            tick(1'b0, 1'b0);
        end
        run_until(1'b1, P_RUN, 120, "sat_final");
        repeat (5) tick(1'b1, 1'b0);

        // Reset in the middle of RUN
        do_reset();
        run_until(1'b1, P_RUN, 100, "after_reset");
        repeat (10) tick(1'b1, 1'b0);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected events left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
